// File: rtl/serial_eq_pkg.sv
// Shared types and defaults for the serial equality sequencer.
package serial_eq_pkg;

  localparam int unsigned SEQ_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pair_eq.sv
// Two-pair equality unit: s is high when a==b and c==d.
module pair_eq (
  output logic s,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d
);

  logic w1;
  logic w2;

  // Compare each bit pair, then combine.
  always_comb begin
    w1 = (a == b);
    w2 = (c == d);
    s  = w1 & w2;
  end

endmodule

// File: rtl/serial_eq_ctrl.sv
// Serial word-equality sequencer: loads two WIDTH-bit operands on start,
// compares them two bit-pairs per cycle through pair_eq (LSB first) and
// reports overall equality plus the index of the first mismatching pair.
// Optional build macro SERIAL_EQ_EARLY_EXIT_EN: finish on the first
// mismatching pair instead of running all NPAIR steps.
module serial_eq_ctrl
  import serial_eq_pkg::*;
#(
  parameter  int unsigned WIDTH = SEQ_DEFAULT_WIDTH,
  localparam int unsigned NPAIR = WIDTH / 2,
  localparam int unsigned IDXW  = $clog2(NPAIR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDXW-1:0]  miss_idx
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("serial_eq_ctrl: WIDTH must be even and >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             acc_q, acc_d;
  logic             eq_q, eq_d;
  logic [IDXW-1:0]  miss_idx_q, miss_idx_d;

  logic pair_ok;
  logic last_step;

  pair_eq u_pair_eq (
    .s (pair_ok),
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .c (a_sh_q[1]),
    .d (b_sh_q[1])
  );

  assign last_step = (idx_q == IDXW'(NPAIR - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_d = S_DONE;
        end
`ifdef SERIAL_EQ_EARLY_EXIT_EN
        if (!pair_ok) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    ready    = (state_q == S_IDLE);
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    eq       = eq_q;
    miss_idx = miss_idx_q;
  end

  // Datapath next values: operand load, pair shift, accumulate, result capture.
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    eq_d       = eq_q;
    miss_idx_d = miss_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d     = a_in;
          b_sh_d     = b_in;
          idx_d      = '0;
          acc_d      = 1'b1;
          miss_idx_d = IDXW'(NPAIR);
        end
      end
      S_RUN: begin
        acc_d  = acc_q & pair_ok;
        a_sh_d = a_sh_q >> 2;
        b_sh_d = b_sh_q >> 2;
        // acc_q still high means no earlier pair has mismatched.
        if (!pair_ok && acc_q) begin
          miss_idx_d = idx_q;
        end
        // idx saturates at NPAIR-1 so it never wraps.
        if (!last_step) begin
          idx_d = idx_q + IDXW'(1);
        end
        if (last_step) begin
          eq_d = acc_q & pair_ok;
        end
`ifdef SERIAL_EQ_EARLY_EXIT_EN
        if (!pair_ok) begin
          eq_d = 1'b0;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      idx_q      <= '0;
      acc_q      <= 1'b0;
      eq_q       <= 1'b0;
      miss_idx_q <= '0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      eq_q       <= eq_d;
      miss_idx_q <= miss_idx_d;
    end
  end

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Directed self-checking bench for serial_eq_ctrl (WIDTH=8 and WIDTH=2).
module tb_serial_eq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       eq;
  logic [2:0] miss_idx;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       ready2;
  logic       busy2;
  logic       done2;
  logic       eq2;
  logic [0:0] miss_idx2;

  int errors = 0;
  int checks = 0;
  logic last_eq;

  serial_eq_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .miss_idx (miss_idx)
  );

  serial_eq_ctrl #(.WIDTH(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .a_in     (a2),
    .b_in     (b2),
    .ready    (ready2),
    .busy     (busy2),
    .done     (done2),
    .eq       (eq2),
    .miss_idx (miss_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edges from the accepting edge to the first edge after which done is high.
  function automatic int exp_edges(input logic e, input int idx);
`ifdef SERIAL_EQ_EARLY_EXIT_EN
    return e ? 4 : idx + 1;
`else
    return 4;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic e, input logic [2:0] idx);
    int n;
    @(negedge clk);
    check({tag, ".ready"}, ready, 1);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".eq_hold"}, eq, last_eq);
    check({tag, ".idx_at_accept"}, miss_idx, 4);
    // start and operand changes while running must be ignored
    a_in = ~a;
    b_in = a;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
    start = 1'b0;
    check({tag, ".latency"}, n, exp_edges(e, idx));
    check({tag, ".eq"}, eq, e);
    check({tag, ".miss_idx"}, miss_idx, idx);
    last_eq = e;
    @(posedge clk);
    #1;
    check({tag, ".ready_after"}, ready, 1);
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int dones;
    logic e;
    logic [2:0] idx;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    last_eq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.ready", ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.eq", eq, 0);
    check("rst.miss_idx", miss_idx, 0);
    check("rst.ready2", ready2, 1);

    run_op("a5_a5", 8'hA5, 8'hA5, 1'b1, 3'd4);
    run_op("a5_a4", 8'hA5, 8'hA4, 1'b0, 3'd0);
    run_op("35_b5", 8'h35, 8'hB5, 1'b0, 3'd3);
    run_op("0f_f0", 8'h0F, 8'hF0, 1'b0, 3'd0);
    run_op("12_16", 8'h12, 8'h16, 1'b0, 3'd1);
    run_op("00_00", 8'h00, 8'h00, 1'b1, 3'd4);

    // start held high, alternating equal / unequal operand pairs
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'hA5;
    b_in  = 8'hA5;
    for (int op = 0; op < 4; op++) begin
      e   = (op % 2 == 0);
      idx = e ? 3'd4 : 3'd0;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!done && n < 30);
      check("cont.period", n, (op == 0 ? 1 : 2) + exp_edges(e, int'(idx)));
      check("cont.eq", eq, e);
      check("cont.miss_idx", miss_idx, idx);
      if (op % 2 == 0) begin
        a_in = 8'h0F;
        b_in = 8'hF0;
      end else begin
        a_in = 8'hA5;
        b_in = 8'hA5;
      end
    end
    start = 1'b0;
    last_eq = 1'b0;
    @(posedge clk);
    #1;

    run_op("pre_rst", 8'h5A, 8'h5A, 1'b1, 3'd4);

    // reset during the third RUN cycle abandons the operation
    @(negedge clk);
    a_in  = 8'h5A;
    b_in  = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("mid.busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst.ready", ready, 1);
    check("mid_rst.busy", busy, 0);
    check("mid_rst.eq", eq, 0);
    check("mid_rst.miss_idx", miss_idx, 0);
    dones = 0;
    repeat (8) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("mid_rst.no_done", dones, 0);
    last_eq = 1'b0;
    run_op("after_rst", 8'h0F, 8'h0F, 1'b1, 3'd4);

    // WIDTH=2 instance
    @(negedge clk);
    check("w2.ready", ready2, 1);
    a2 = 2'b10;
    b2 = 2'b10;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done2 && n < 10);
    check("w2_eq.latency", n, 1);
    check("w2_eq.eq", eq2, 1);
    check("w2_eq.miss_idx", miss_idx2, 1);
    @(negedge clk);
    @(negedge clk);
    check("w2.ready_again", ready2, 1);
    a2 = 2'b10;
    b2 = 2'b11;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done2 && n < 10);
    check("w2_ne.latency", n, 1);
    check("w2_ne.eq", eq2, 0);
    check("w2_ne.miss_idx", miss_idx2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_eq_ctrl.md
Name: serial_eq_ctrl

Overview:
- Sequencer that compares two WIDTH-bit words for equality by time-sharing one 2-pair equality unit, which compares two bit-pairs per cycle.
- Loads both operands on a start handshake, then shifts them through the pair comparator LSB-first and accumulates the result.
- Reports overall equality and the index of the first mismatching pair.
- Sits between a word-level requester and the bit-level equality datapath.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2; elaboration error otherwise.
- NPAIR (localparam), WIDTH/2, number of 2-bit comparison steps.
- IDXW (localparam), clog2(NPAIR+1), width of miss_idx.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only when ready=1.
- a_in  in  WIDTH  operand A. Sampled on the accepting edge only.
- b_in  in  WIDTH  operand B. Sampled on the accepting edge only.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; high in DONE.
- eq  out  1  1 = operands equal. Valid from done; held until the next accepted start.
- miss_idx  out  IDXW  pair index (0 = bits[1:0]) of the first mismatch. NPAIR when equal. Same validity as eq.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, done=0, eq=0, miss_idx=0, shift registers=0, step counter=0. Applies in any state; an operation in flight is abandoned with no done pulse.
- States and transitions:
  - IDLE: start=1 at edge k → load a_sh<=a_in, b_sh<=b_in, idx<=0, acc<=1, miss_idx<=NPAIR; go to RUN.
  - RUN: each edge computes p = (a_sh[0]==b_sh[0]) & (a_sh[1]==b_sh[1]) via the pair unit.
    - acc<=acc&p.
    - If p=0 and acc=1, miss_idx<=idx (records first mismatch only).
    - a_sh/b_sh shift right by 2, zero-filled; idx<=idx+1.
    - When idx==NPAIR-1, go to DONE and set eq<=acc&p.
  - DONE: done=1 for exactly one cycle; next edge → IDLE.
- Latency: start accepted at edge k → RUN during edges k+1..k+NPAIR → done=1 in the cycle after edge k+NPAIR (NPAIR+1 cycles from acceptance). Next start is accepted at edge k+NPAIR+2 at the earliest.
- start while RUN or DONE: ignored and not queued. Operands that change after acceptance have no effect.
- idx never wraps; its maximum is NPAIR-1.
- eq and miss_idx are not cleared by done. They change only on reset or on an accepted start (eq is not modified at accept; it updates only on entry to DONE).

Optional Feature:
- Macro: SERIAL_EQ_EARLY_EXIT_EN
- Defined: in RUN, if p=0 the FSM goes to DONE on that same edge with eq<=0 and miss_idx<=idx. Latency becomes miss_idx+2 cycles from acceptance on mismatch; unchanged when operands are equal.
- Undefined: all NPAIR steps always run; latency is fixed at NPAIR+1.

Decomposition:
- Package serial_eq_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - default WIDTH.
- Sub-module pair_eq (ports s, a, b, c, d; internal w1=(a==b), w2=(c==d); s=w1&w2), purely combinational, instantiated once. The FSM, shift registers and counter stay in serial_eq_ctrl.

Test Plan:
- a=8'hA5, b=8'hA5, start 1 cycle → done exactly 5 cycles after accept, eq=1, miss_idx=4; ready back 1 cycle later.
- a=8'hA5, b=8'hA4 → eq=0, miss_idx=0. Without the macro done at accept+5; with SERIAL_EQ_EARLY_EXIT_EN done at accept+2.
- a=8'h35, b=8'hB5 → eq=0, miss_idx=3. a=8'h0F, b=8'hF0 → eq=0, miss_idx=0 (first mismatch only, not the last).
- start held high continuously with alternating operand pairs → one operation per 6 cycles. start and operand changes during RUN are ignored; eq and miss_idx hold their previous results until the next done.
- rst asserted during the 3rd RUN cycle → next cycle ready=1, busy=0, eq=0, miss_idx=0, and no done pulse appears. A fresh start then completes normally.
- WIDTH=2 instance: a=2'b10, b=2'b10 → done at accept+2, eq=1, miss_idx=1.
